// File: rtl/color_rand_pkg.sv
// Shared types and constants for the colour generator: FSM states, default LFSR taps/seed,
// and the bound on ball-slot pick retries.
package color_rand_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    PICK = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEF_TAPS       = 32'h80200003;
  localparam logic [31:0] DEF_SEED       = 32'h000000B5;
  localparam logic [1:0]  PICK_MAX_RETRY = 2'd3;

endpackage

// File: rtl/lfsr_core.sv
// Free-running right-shift Galois LFSR with a synchronous seed load.
// A zero seed, either as reset value or as a loaded value, is replaced by 1.
module lfsr_core
  import color_rand_pkg::*;
#(
  parameter int           W    = 32,
  parameter logic [W-1:0] TAPS = W'(DEF_TAPS),
  parameter logic [W-1:0] SEED = W'(DEF_SEED)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? ONE : SEED;

  // TAPS has its top bit set, so a step can never produce zero.
  function automatic logic [W-1:0] galois_step(input logic [W-1:0] v);
    galois_step = (v >> 1) ^ (v[0] ? TAPS : '0);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= SEED_NZ;
    end else if (load) begin
      q <= (load_val == '0) ? ONE : load_val;
    end else begin
      q <= galois_step(q);
    end
  end

endmodule

// File: rtl/color_rand_gen.sv
// Successor colour generator: fills NUM_PLATS slots from an LFSR, then picks the ball slot.
// Define COLOR_DISTINCT_EN to force pairwise-distinct platform colours.
module color_rand_gen
  import color_rand_pkg::*;
#(
  parameter int                NUM_PLATS = 4,
  parameter int                COLOR_W   = 3,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED),
  localparam int               PW        = $clog2(NUM_PLATS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         seed_load,
  input  logic [LFSR_W-1:0]            seed_in,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PLATS*COLOR_W-1:0] plats_color,
  output logic [COLOR_W-1:0]           ball_color,
  output logic [PW-1:0]                ball_pos
);

  localparam int unsigned   NP   = NUM_PLATS;
  localparam logic [PW-1:0] LAST = PW'(NUM_PLATS - 1);

  if (NUM_PLATS < 2 || NUM_PLATS > 16) begin : g_bad_num_plats
    $error("color_rand_gen: NUM_PLATS must be in 2..16");
  end

  state_t                       state;
  state_t                       state_next;
  logic [LFSR_W-1:0]            lfsr_q;
  logic                         unused_lfsr_bits;
  logic [COLOR_W-1:0]           shadow [NUM_PLATS];
  logic [NUM_PLATS*COLOR_W-1:0] shadow_flat;
  logic [PW-1:0]                slot_idx;
  logic [1:0]                   retry_cnt;
  logic [COLOR_W-1:0]           slot_color;
  logic                         slot_wr;
  logic                         dup;
  logic                         pick_done;
  logic [PW-1:0]                pick_pos;
  int unsigned                  cand;

`ifdef COLOR_DISTINCT_EN
  logic                         retry_pending;
  logic [COLOR_W-1:0]           inc_color;

  if (NUM_PLATS > (1 << COLOR_W)) begin : g_bad_distinct
    $error("color_rand_gen: distinct colours need NUM_PLATS <= 2**COLOR_W");
  end
`endif

  lfsr_core #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (lfsr_q)
  );

  assign unused_lfsr_bits = ^lfsr_q;
  assign busy             = (state == GEN) || (state == PICK);

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < NUM_PLATS; k++) begin
      shadow_flat[k*COLOR_W +: COLOR_W] = shadow[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    slot_color = lfsr_q[COLOR_W-1:0];
    dup        = 1'b0;
    slot_wr    = 1'b0;
    pick_done  = 1'b0;
    cand       = 32'(lfsr_q[PW-1:0]);
    pick_pos   = lfsr_q[PW-1:0];
    case (state)
      IDLE: state_next = start ? GEN : IDLE;
      GEN: begin
`ifdef COLOR_DISTINCT_EN
        // A retried slot uses the incremented colour, not a fresh LFSR draw.
        slot_color = retry_pending ? inc_color : lfsr_q[COLOR_W-1:0];
        for (int j = 0; j < NUM_PLATS; j++) begin
          dup = dup | ((PW'(j) < slot_idx) && (shadow[j] == slot_color));
        end
`endif
        slot_wr    = ~dup;
        state_next = (slot_wr && (slot_idx == LAST)) ? PICK : GEN;
      end
      PICK: begin
        if (cand < NP) begin
          pick_done = 1'b1;
        end else if (retry_cnt == PICK_MAX_RETRY) begin
          pick_done = 1'b1;
          pick_pos  = PW'(cand % NP);
        end else begin
          pick_done = 1'b0;
        end
        state_next = pick_done ? DONE : PICK;
      end
      DONE:    state_next = out_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_PLATS; k++) begin
        shadow[k] <= '0;
      end
      slot_idx    <= '0;
      retry_cnt   <= 2'd0;
      out_valid   <= 1'b0;
      plats_color <= '0;
      ball_color  <= '0;
      ball_pos    <= '0;
`ifdef COLOR_DISTINCT_EN
      retry_pending <= 1'b0;
      inc_color     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          slot_idx  <= '0;
          retry_cnt <= 2'd0;
`ifdef COLOR_DISTINCT_EN
          retry_pending <= 1'b0;
`endif
        end
        GEN: begin
          if (slot_wr) begin
            shadow[slot_idx] <= slot_color;
            slot_idx         <= slot_idx + PW'(1);
          end
`ifdef COLOR_DISTINCT_EN
          retry_pending <= ~slot_wr;
          inc_color     <= slot_color + COLOR_W'(1);
`endif
        end
        // Results are published in a single edge so consumers never see a mixed set.
        PICK: begin
          if (pick_done) begin
            plats_color <= shadow_flat;
            ball_pos    <= pick_pos;
            ball_color  <= shadow[pick_pos];
            out_valid   <= 1'b1;
          end else begin
            retry_cnt <= retry_cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_rand_gen.sv
// Self-checking bench for color_rand_gen: three instances (4, 5 and 8 slots) checked against
// a spec-level model that replays the free-running LFSR sequence.
module tb_color_rand_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v     [3];
  logic        seed_load_v [3];
  logic        out_ready_v [3];
  logic [31:0] seed_in_v   [3];
  wire         busy_a      [3];
  wire         valid_a     [3];
  wire  [2:0]  col_a       [3];
  wire  [63:0] plats_a     [3];
  wire  [3:0]  pos_a       [3];
  wire  [11:0] pc0;
  wire  [14:0] pc1;
  wire  [23:0] pc2;
  wire  [1:0]  bp0;
  wire  [2:0]  bp1;
  wire  [2:0]  bp2;

  logic [31:0] m [3];
  logic [63:0] exp_plats [3];
  int          exp_pos   [3];
  logic [2:0]  exp_col   [3];
  int          tests_run    = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  assign plats_a[0] = {52'd0, pc0};
  assign plats_a[1] = {49'd0, pc1};
  assign plats_a[2] = {40'd0, pc2};
  assign pos_a[0]   = {2'd0, bp0};
  assign pos_a[1]   = {1'b0, bp1};
  assign pos_a[2]   = {1'b0, bp2};

  color_rand_gen #(.NUM_PLATS(4), .COLOR_W(3)) dut0 (
    .clk(clk), .reset(rst), .start(start_v[0]), .seed_load(seed_load_v[0]),
    .seed_in(seed_in_v[0]), .busy(busy_a[0]), .out_valid(valid_a[0]),
    .out_ready(out_ready_v[0]), .plats_color(pc0), .ball_color(col_a[0]), .ball_pos(bp0));

  color_rand_gen #(.NUM_PLATS(5), .COLOR_W(3)) dut1 (
    .clk(clk), .reset(rst), .start(start_v[1]), .seed_load(seed_load_v[1]),
    .seed_in(seed_in_v[1]), .busy(busy_a[1]), .out_valid(valid_a[1]),
    .out_ready(out_ready_v[1]), .plats_color(pc1), .ball_color(col_a[1]), .ball_pos(bp1));

  color_rand_gen #(.NUM_PLATS(8), .COLOR_W(3)) dut2 (
    .clk(clk), .reset(rst), .start(start_v[2]), .seed_load(seed_load_v[2]),
    .seed_in(seed_in_v[2]), .busy(busy_a[2]), .out_valid(valid_a[2]),
    .out_ready(out_ready_v[2]), .plats_color(pc2), .ball_color(col_a[2]), .ball_pos(bp2));

  function automatic int np(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 5 : 8);
  endfunction

  // Galois polynomial x^32+x^22+x^2+x+1, shifting towards bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  // Whole run from the LFSR value seen in the first GEN cycle: slot colours, ball slot, cycles busy.
  function automatic void model_run(input int n, input logic [31:0] v0,
                                    output logic [63:0] plats, output int pos, output int cycles);
    logic [31:0] v;
    bit          taken [8];
    int          c;
    int          pw;
    int          cand;
    v = v0;
    plats = 64'd0;
    pos = 0;
    cycles = 0;
    for (int i = 0; i < 8; i++) taken[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      c = int'(v[2:0]);
`ifdef COLOR_DISTINCT_EN
      while (taken[c]) begin
        c = (c + 1) % 8;
        v = lfsr_next(v);
        cycles++;
      end
`endif
      taken[c] = 1'b1;
      plats = plats | (64'(c) << (3 * k));
      v = lfsr_next(v);
      cycles++;
    end
    pw = $clog2(n);
    for (int r = 0; r < 4; r++) begin
      cand = int'(v & ((32'd1 << pw) - 32'd1));
      cycles++;
      if (cand < n) begin
        pos = cand;
        break;
      end
      if (r == 3) begin
        pos = cand % n;
        break;
      end
      v = lfsr_next(v);
    end
  endfunction

  // One clock edge; the reference LFSRs follow the same edge.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) m[d] = 32'h000000B5;
      else if (seed_load_v[d]) m[d] = (seed_in_v[d] == 32'd0) ? 32'd1 : seed_in_v[d];
      else m[d] = lfsr_next(m[d]);
    end
    #1;
  endtask

  task automatic load_seed(input int d, input logic [31:0] s);
    seed_load_v[d] = 1'b1;
    seed_in_v[d] = s;
    tick();
    seed_load_v[d] = 1'b0;
  endtask

  task automatic run_check(input int d, input string tag);
    logic [63:0] ep;
    int epos, lat, cnt, bcnt;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    model_run(np(d), m[d], ep, epos, lat);
    cnt = 0;
    bcnt = 0;
    while (valid_a[d] !== 1'b1 && cnt < 300) begin
      if (busy_a[d] === 1'b1) bcnt++;
      tick();
      cnt++;
    end
    exp_plats[d] = ep;
    exp_pos[d] = epos;
    exp_col[d] = 3'(ep >> (3 * epos));
    tests_run++;
    if (cnt !== lat) begin
      tests_failed++;
      $display("FAIL %s latency d%0d: got %0d edges, expected %0d", tag, d, cnt, lat);
    end
    tests_run++;
    if (bcnt !== lat) begin
      tests_failed++;
      $display("FAIL %s busy_cycles d%0d: got %0d, expected %0d", tag, d, bcnt, lat);
    end
    tests_run++;
    if (busy_a[d] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy_in_done d%0d: got %b, expected 0", tag, d, busy_a[d]);
    end
    tests_run++;
    if (plats_a[d] !== ep) begin
      tests_failed++;
      $display("FAIL %s plats_color d%0d: got %0h, expected %0h", tag, d, plats_a[d], ep);
    end
    tests_run++;
    if (pos_a[d] !== 4'(epos)) begin
      tests_failed++;
      $display("FAIL %s ball_pos d%0d: got %0d, expected %0d", tag, d, pos_a[d], epos);
    end
    tests_run++;
    if (col_a[d] !== exp_col[d]) begin
      tests_failed++;
      $display("FAIL %s ball_color d%0d: got %0d, expected %0d", tag, d, col_a[d], exp_col[d]);
    end
  endtask

  task automatic accept(input int d, input string tag);
    out_ready_v[d] = 1'b1;
    tick();
    out_ready_v[d] = 1'b0;
    tests_run++;
    if (valid_a[d] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s valid_drop d%0d: got %b, expected 0", tag, d, valid_a[d]);
    end
    tests_run++;
    if (plats_a[d] !== exp_plats[d]) begin
      tests_failed++;
      $display("FAIL %s data_kept d%0d: got %0h, expected %0h", tag, d, plats_a[d], exp_plats[d]);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      tests_run++;
      if ({valid_a[d], busy_a[d], plats_a[d], col_a[d], pos_a[d]} !== 73'd0) begin
        tests_failed++;
        $display("FAIL %s d%0d: got valid=%b busy=%b plats=%0h col=%0d pos=%0d, expected all 0",
                 tag, d, valid_a[d], busy_a[d], plats_a[d], col_a[d], pos_a[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_default();
    run_check(0, "first_run_from_seed");
    accept(0, "first_run_from_seed");
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      run_check(0, "default_random");
      accept(0, "default_random");
    end
  endtask

  task automatic test_seed_load();
    for (int i = 0; i < 2; i++) begin
      load_seed(0, 32'h12345678);
      run_check(0, "seed_12345678");
      accept(0, "seed_12345678");
    end
    load_seed(0, 32'd0);
    run_check(0, "seed_zero");
    accept(0, "seed_zero");
    load_seed(0, 32'd1);
    run_check(0, "seed_one");
    accept(0, "seed_one");
  endtask

  task automatic test_hold();
    run_check(0, "hold");
    for (int i = 0; i < 20; i++) begin
      start_v[0] = (i == 7);
      tick();
      tests_run++;
      if (valid_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || plats_a[0] !== exp_plats[0]
          || pos_a[0] !== 4'(exp_pos[0]) || col_a[0] !== exp_col[0]) begin
        tests_failed++;
        $display("FAIL hold_stable cycle %0d: got valid=%b busy=%b plats=%0h pos=%0d, expected 1 0 %0h %0d",
                 i, valid_a[0], busy_a[0], plats_a[0], pos_a[0], exp_plats[0], exp_pos[0]);
      end
    end
    start_v[0] = 1'b0;
    accept(0, "hold");
    tick();
    tests_run++;
    if (busy_a[0] !== 1'b0 || valid_a[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_no_queue: got busy=%b valid=%b, expected 0 0", busy_a[0], valid_a[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_check(0, "b2b");
    start_v[0] = 1'b1;
    out_ready_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    out_ready_v[0] = 1'b0;
    tests_run++;
    if (valid_a[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_valid_drop: got %b, expected 0", valid_a[0]);
    end
    tick();
    tests_run++;
    if (busy_a[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_start_dropped: got busy=%b, expected 0", busy_a[0]);
    end
  endtask

  task automatic test_rejections();
    logic [31:0] s;
    logic [63:0] ep;
    int epos, lat;
    bit found;
    found = 1'b0;
    s = 32'd1;
    for (int t = 0; t < 5000 && !found; t++) begin
      s = $urandom;
      if (s == 32'd0) s = 32'd1;
      model_run(5, lfsr_next(s), ep, epos, lat);
      found = (lat == 5 + 4);
    end
    for (int i = 0; i < 25; i++) begin
      if (i == 0 && found) load_seed(1, s);
      else repeat ($urandom_range(0, 4)) tick();
      run_check(1, "n5_pick");
      tests_run++;
      if (pos_a[1] > 4'd4) begin
        tests_failed++;
        $display("FAIL n5_pos_range: got %0d, expected <= 4", pos_a[1]);
      end
      accept(1, "n5_pick");
    end
  endtask

  task automatic test_distinct();
    logic [7:0] mask;
    int runs;
`ifdef COLOR_DISTINCT_EN
    runs = 1000;
`else
    runs = 30;
`endif
    for (int i = 0; i < runs; i++) begin
      if ($urandom_range(0, 9) == 0) load_seed(2, $urandom);
      run_check(2, "n8_run");
`ifdef COLOR_DISTINCT_EN
      mask = 8'd0;
      for (int k = 0; k < 8; k++) mask[plats_a[2][3*k +: 3]] = 1'b1;
      tests_run++;
      if (mask !== 8'hFF) begin
        tests_failed++;
        $display("FAIL n8_permutation: got colour set %b, expected 11111111", mask);
      end
`endif
      accept(2, "n8_run");
    end
  endtask

  task automatic test_reset_midrun();
    run_check(0, "midrun_pre");
    accept(0, "midrun_pre");
    for (int d = 0; d < 3; d++) start_v[d] = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_zero("reset_midrun");
    tick();
    rst = 1'b0;
    tick();
    check_zero("after_reset_idle");
    run_check(0, "post_reset");
    accept(0, "post_reset");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0;
      seed_load_v[d] = 1'b0;
      out_ready_v[d] = 1'b0;
      seed_in_v[d] = 32'd0;
      m[d] = 32'h000000B5;
    end
    test_reset();
    test_default();
    test_seed_load();
    test_hold();
    test_back_to_back();
    test_rejections();
    test_distinct();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
